// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the SRAM bus slave.
package bus_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACK, RELEASE} state_t;
    localparam logic [15:0] ERR_DATA = 16'hDEAD;
    localparam logic [23:0] DEFAULT_BASE_ADDR = 24'h800000;
endpackage

// File: rtl/bus_slave_ram.sv
// bus_slave_ram: single-port RAM, synchronous read, byte-enable write.
module bus_slave_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);
    logic [15:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we && be[0]) mem[addr][7:0] <= wdata[7:0];
        if (we && be[1]) mem[addr][15:8] <= wdata[15:8];
        rdata <= mem[addr];
    end
endmodule

// File: rtl/bus_slave_sram.sv
// bus_slave_sram: wait-stated SRAM slave with window/conflict error reporting.
module bus_slave_sram
    import bus_pkg::*;
#(
    parameter int          WAIT_STATES = 2,
    parameter logic [23:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          DEPTH_LOG2  = 11
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [23:0] iAddr,
    input  logic        iRead,
    input  logic        iWrite,
    input  logic [1:0]  iBE,
    input  logic [15:0] iData,
    output logic        oACK,
    output logic [15:0] oData,
    output logic        oERR
);
    localparam logic [24:0] WIN_SIZE = 25'(1) << (DEPTH_LOG2 + 1);
    localparam logic [3:0]  CNT_LAST = 4'(WAIT_STATES - 1);
    state_t                state, state_n;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] c_idx;
    logic [1:0]            c_be;
    logic [15:0]           c_data, hold, ram_q;
    logic                  c_rd, c_wr, c_bad;
    logic [24:0]           offset;
    logic                  req, bad_addr, rd_ack;
    assign req      = iRead | iWrite;
    // 25-bit offset keeps the window-end compare free of wraparound
    assign offset   = {1'b0, iAddr} - {1'b0, BASE_ADDR};
    assign bad_addr = (iAddr < BASE_ADDR) || (offset >= WIN_SIZE);
    assign rd_ack   = (state == ACK) && c_rd && !c_wr;
    assign oACK     = state == ACK;
    assign oERR     = (state == ACK) && (c_bad || (c_rd && c_wr));
    assign oData    = rd_ack ? (c_bad ? ERR_DATA : ram_q) : hold;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req) state_n = (WAIT_STATES == 0) ? ACK : WAIT;
            WAIT:    if (cnt == CNT_LAST) state_n = ACK;
            ACK:     state_n = RELEASE;
            RELEASE: if (!req) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state == WAIT) ? cnt + 4'd1 : '0;
            if (rd_ack) hold <= oData;
        end
    end
    always_ff @(posedge iCLK) begin
        if (state == IDLE && req) begin
            c_idx  <= iAddr[DEPTH_LOG2:1];
            c_be   <= iBE;
            c_data <= iData;
            c_rd   <= iRead;
            c_wr   <= iWrite;
            c_bad  <= bad_addr;
        end
    end
    // In IDLE the RAM looks at the live bus so a zero-wait read is ready in ACK
    bus_slave_ram #(.AW(DEPTH_LOG2)) u_ram (
        .clk   (iCLK),
        .addr  ((state == IDLE) ? iAddr[DEPTH_LOG2:1] : c_idx),
        .we    ((state == ACK) && c_wr && !c_rd && !c_bad),
        .be    (c_be),
        .wdata (c_data),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_bus_slave_sram.sv
// tb_bus_slave_sram: directed vector table plus reset/burst sequences for bus_slave_sram.
module tb_bus_slave_sram;
    logic        iCLK = 0, iRST = 1, iRead = 0, iWrite = 0;
    logic [23:0] iAddr = '0;
    logic [1:0]  iBE = '0;
    logic [15:0] iData = '0;
    logic        oACK, oERR;
    logic [15:0] oData;
    int total = 0, bad = 0, acks = 0;

    bus_slave_sram dut (
        .iCLK(iCLK), .iRST(iRST), .iAddr(iAddr), .iRead(iRead), .iWrite(iWrite),
        .iBE(iBE), .iData(iData), .oACK(oACK), .oData(oData), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) if (oACK === 1'b1) acks++;

    typedef struct {
        logic        rd, wr;
        logic [23:0] a;
        logic [1:0]  be;
        logic [15:0] d;
        logic        err, chk;
        logic [15:0] ed;
    } vec_t;
    vec_t v[16];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Drives one request, master holds it one cycle beyond the ack, then idles a cycle.
    task automatic xact(input logic rd, input logic wr, input logic [23:0] a, input logic [1:0] be,
                        input logic [15:0] d, input logic eerr, input logic chk,
                        input logic [15:0] ed, input string nm);
        int cyc = 0;
        iRead = rd; iWrite = wr; iAddr = a; iBE = be; iData = d;
        do begin
            @(posedge iCLK); @(negedge iCLK); cyc++;
        end while (oACK !== 1'b1 && cyc < 20);
        check({nm, " latency"}, cyc, 3);
        check({nm, " err"}, oERR, eerr);
        if (chk) check({nm, " data"}, oData, ed);
        @(negedge iCLK);
        check({nm, " ack pulse"}, {oACK, oERR}, 2'b00);
        @(negedge iCLK);
        iRead = 0; iWrite = 0;
        check({nm, " no reserve"}, oACK, 1'b0);
        @(negedge iCLK);
    endtask

    initial begin
        int a0, cyc;
        v[0]  = '{1'b0, 1'b1, 24'h800000, 2'b11, 16'h1111, 1'b0, 1'b0, 16'h0000};
        v[1]  = '{1'b1, 1'b0, 24'h800000, 2'b00, 16'h0000, 1'b0, 1'b1, 16'h1111};
        v[2]  = '{1'b0, 1'b1, 24'h800002, 2'b11, 16'hABCD, 1'b0, 1'b0, 16'h0000};
        v[3]  = '{1'b0, 1'b1, 24'h800002, 2'b10, 16'h1200, 1'b0, 1'b0, 16'h0000};
        v[4]  = '{1'b1, 1'b0, 24'h800002, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h12CD};
        v[5]  = '{1'b1, 1'b0, 24'h801000, 2'b11, 16'h0000, 1'b1, 1'b1, 16'hDEAD};
        v[6]  = '{1'b0, 1'b1, 24'h801000, 2'b11, 16'hBEEF, 1'b1, 1'b0, 16'h0000};
        v[7]  = '{1'b1, 1'b0, 24'h800000, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h1111};
        v[8]  = '{1'b0, 1'b1, 24'h800FFE, 2'b11, 16'h7777, 1'b0, 1'b0, 16'h0000};
        v[9]  = '{1'b0, 1'b1, 24'h7FFFFE, 2'b11, 16'h5555, 1'b1, 1'b0, 16'h0000};
        v[10] = '{1'b0, 1'b1, 24'h800FFE, 2'b00, 16'h0000, 1'b0, 1'b0, 16'h0000};
        v[11] = '{1'b1, 1'b0, 24'h800FFE, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h7777};
        v[12] = '{1'b1, 1'b1, 24'h800FFE, 2'b11, 16'hFFFF, 1'b1, 1'b1, 16'h7777};
        v[13] = '{1'b1, 1'b0, 24'h800FFE, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h7777};
        v[14] = '{1'b1, 1'b0, 24'hFFFFFE, 2'b11, 16'h0000, 1'b1, 1'b1, 16'hDEAD};
        v[15] = '{1'b0, 1'b1, 24'h800010, 2'b11, 16'h4242, 1'b0, 1'b0, 16'h0000};

        repeat (3) @(negedge iCLK);
        check("reset outputs", {oACK, oERR, oData}, 18'h0);
        iRST = 0;
        @(negedge iCLK);
        check("idle outputs", {oACK, oERR, oData}, 18'h0);

        for (int i = 0; i < 16; i++)
            xact(v[i].rd, v[i].wr, v[i].a, v[i].be, v[i].d, v[i].err, v[i].chk, v[i].ed,
                 $sformatf("vec%0d", i));

        // Abort: reset in WAIT with the request withdrawn
        a0 = acks;
        iWrite = 1; iAddr = 24'h800010; iBE = 2'b11; iData = 16'h5A5A;
        repeat (2) @(negedge iCLK);
        iRST = 1; iWrite = 0;
        @(negedge iCLK);
        check("abort reset oData", {oACK, oData}, 17'h0);
        iRST = 0;
        repeat (3) @(negedge iCLK);
        check("abort no ack", acks - a0, 0);
        xact(1'b1, 1'b0, 24'h800010, 2'b11, 16'h0, 1'b0, 1'b1, 16'h4242, "abort word");

        // Held request through reset is served as new
        a0 = acks;
        iWrite = 1; iAddr = 24'h800010; iBE = 2'b11; iData = 16'h9999;
        @(negedge iCLK);
        iRST = 1;
        @(negedge iCLK);
        iRST = 0;
        cyc = 0;
        do begin
            @(posedge iCLK); @(negedge iCLK); cyc++;
        end while (oACK !== 1'b1 && cyc < 20);
        check("held latency", cyc, 3);
        @(negedge iCLK);
        iWrite = 0;
        check("held ack count", acks - a0, 1);
        repeat (2) @(negedge iCLK);
        xact(1'b1, 1'b0, 24'h800010, 2'b11, 16'h0, 1'b0, 1'b1, 16'h9999, "held word");

        a0 = acks;
        for (int i = 0; i < 2048; i++)
            xact(1'b0, 1'b1, 24'h800000 + 24'(2 * i), 2'b11, 16'(16'h1111 + i), 1'b0, 1'b0, 16'h0,
                 $sformatf("fill%0d", i));
        check("fill ack count", acks - a0, 2048);
        for (int i = 0; i < 2048; i++)
            xact(1'b1, 1'b0, 24'h800000 + 24'(2 * i), 2'b01, 16'h0, 1'b0, 1'b1, 16'(16'h1111 + i),
                 $sformatf("readback%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
